// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and state type for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_VALUE     = 4'd3;

    localparam logic IDLE_ENC  = 1'b0;
    localparam logic SHIFT_ENC = 1'b1;

    typedef enum logic {
        IDLE  = IDLE_ENC,
        SHIFT = SHIFT_ENC
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more before the shift.
// Purely combinational, no latency, no flow control.
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] corrected
);

    assign corrected = (digit >= ADD3_THRESHOLD) ? digit + ADD3_VALUE : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one bit per clock: done WIDTH edges after start.
// start is ignored while busy; bcd_out holds the previous result until completion.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam longint MAX_BCD = 64'(10) ** DIGITS;
    localparam longint MAX_BIN = (64'(1) << WIDTH) - 64'(1);

    generate
        if (MAX_BCD <= MAX_BIN) begin : g_digits_too_few
            $error("bin_to_bcd_seq: DIGITS too small to represent 2^WIDTH-1");
        end
    endgenerate

    state_t          state, state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [BW-1:0]    bcd_work;
    logic [BW-1:0]    corrected;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .digit     (bcd_work[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .corrected (corrected[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    assign last_bit = (cnt == CW'(1));
    assign busy     = (state == SHIFT);

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (start) state_nxt = SHIFT;
        end else begin
            if (last_bit) state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The corrected digits shift left with the next binary MSB entering digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bcd_work  <= '0;
            cnt       <= '0;
            bcd_out   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    shift_reg <= bin_in;
                    bcd_work  <= '0;
                    cnt       <= CW'(WIDTH);
                end
            end else begin
                bcd_work  <= {corrected[BW-2:0], shift_reg[WIDTH-1]};
                shift_reg <= shift_reg << 1;
                cnt       <= cnt - CW'(1);
                if (last_bit) begin
                    bcd_out <= {corrected[BW-2:0], shift_reg[WIDTH-1]};
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: arithmetic reference model compared every cycle,
// plus directed literal expectations.
module tb_bin_to_bcd_seq;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int BW     = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  bin_in = '0;
    logic              busy;
    logic              done;
    logic [BW-1:0]     bcd_out;

    int n_checks = 0;
    int n_fail   = 0;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] to_bcd(input int unsigned v);
        logic [BW-1:0] r;
        int unsigned   p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a conversion takes WIDTH edges, then the decimal value appears.
    logic             m_busy;
    logic             m_done;
    logic [BW-1:0]    m_out;
    int unsigned      m_val;
    int               m_rem;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_out  <= '0;
            m_val  <= 0;
            m_rem  <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_val  <= int'(bin_in);
                    m_rem  <= WIDTH;
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_out  <= to_bcd(m_val);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", 32'(busy), 32'(m_busy));
        chk("cyc_done", 32'(done), 32'(m_done));
        chk("cyc_bcd_out", 32'(bcd_out), 32'(m_out));
        for (int d = 0; d < DIGITS; d++)
            chk("digit_range", 32'(bcd_out[4*d +: 4] <= 4'd9), 32'd1);
    end

    task automatic start_conv(input logic [WIDTH-1:0] v);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk); #1;
        start  = 1'b0;
        bin_in = WIDTH'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 40);
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    int n, dcount, dones, cyc;
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_v;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_bcd_out", 32'(bcd_out), 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 12345 with an ignored re-start at k+5
        start_conv(16'd12345);
        n = 0;
        dcount = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) dcount++;
            if (n == 4) begin
                chk("hold_busy", 32'(busy), 32'd1);
                chk("hold_old_out", 32'(bcd_out), 32'h0);
                start  = 1'b1;
                bin_in = 16'd999;
            end
            if (n == 5) start = 1'b0;
        end
        chk("lat_12345", 32'(n), 32'd16);
        chk("val_12345", 32'(bcd_out), 32'h12345);
        repeat (10) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("done_count_12345", 32'(dcount), 32'd1);
        chk("after_12345_idle", 32'(busy), 32'd0);

        start_conv(16'd0);
        wait_done(n);
        chk("val_zero", 32'(bcd_out), 32'h00000);

        start_conv(16'd65535);
        wait_done(n);
        chk("lat_max", 32'(n), 32'd16);
        chk("val_max", 32'(bcd_out), 32'h65535);

        // Back-to-back: second start presented in the done cycle
        start_conv(16'd9);
        wait_done(n);
        chk("val_9", 32'(bcd_out), 32'h00009);
        start  = 1'b1;
        bin_in = 16'd10;
        @(posedge clk); #1;
        start  = 1'b0;
        chk("b2b_accept", 32'(busy), 32'd1);
        chk("b2b_hold_9", 32'(bcd_out), 32'h00009);
        wait_done(n);
        chk("lat_10", 32'(n), 32'd16);
        chk("val_10", 32'(bcd_out), 32'h00010);

        // Asynchronous reset mid-conversion
        start_conv(16'd12345);
        repeat (7) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_bcd_out", 32'(bcd_out), 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_conv(16'd4321);
        wait_done(n);
        chk("post_rst_lat", 32'(n), 32'd16);
        chk("post_rst_val", 32'(bcd_out), 32'h04321);

        // Random sweep with start held high
        start = 1'b1;
        dones = 0;
        cyc   = 0;
        while (dones < 1000 && cyc < 20000) begin
            bin_in = WIDTH'($urandom);
            if (!busy) q.push_back(bin_in);
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                if (q.size() == 0) begin
                    chk("sweep_queue", 32'(q.size()), 32'd1);
                end else begin
                    exp_v = q.pop_front();
                    chk("sweep_val", 32'(bcd_out), 32'(to_bcd(int'(exp_v))));
                end
                dones++;
            end
        end
        start = 1'b0;
        chk("sweep_dones", 32'(dones), 32'd1000);
        chk("sweep_cycles", 32'(cyc), 32'd17000);
        repeat (20) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
